if_stage: RTL and testbench

- Instruction-fetch stage of the toy MIPS core: owns the PC, drives the instruction ROM, and registers the fetched word into the IF/ID pipeline register consumed by decode.
- Sits directly upstream of decode/regfile.
- Accepts stall requests from the hazard logic and branch redirects from the ID stage.
- Honours the single MIPS branch delay slot: the slot is never squashed.

---
 rtl/if_stage.sv | 93 +++++++++
 tb/tb_if_stage.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and
// registers the fetched word into the IF/ID pipeline register.
module if_stage #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [31:0]        NOP_INST = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_if,
  input  logic              stall_id,
  input  logic              branch_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic [31:0]       rom_inst,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [31:0]       id_inst,
  output logic              id_valid,
  output logic [0:0]        dbg_state
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] pc;
  logic              branch_pending;
  logic [ADDR_W-1:0] pending_target;
  logic [ADDR_W-1:0] target_aligned;
  logic [ADDR_W-1:0] next_pc;
  logic              fetch;

  assign target_aligned = {branch_target[ADDR_W-1:2], 2'b00};
  assign fetch          = (state == RUN) && !stall_if && !stall_id;

  assign rom_ce    = (state == RUN);
  assign rom_addr  = pc;
  assign dbg_state = state;

  // A live redirect beats an older pending one; otherwise fall through.
  always_comb begin
    next_pc = pc + ADDR_W'(4);
    if (branch_flag)
      next_pc = target_aligned;
    else if (branch_pending)
      next_pc = pending_target;
  end

  // id_valid qualifies id_pc/id_inst: 1 only when a real fetched word sits in ID.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      id_pc          <= '0;
      id_inst        <= NOP_INST;
      id_valid       <= 1'b0;
      branch_pending <= 1'b0;
      pending_target <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= RUN;
          if (branch_flag) begin
            branch_pending <= 1'b1;
            pending_target <= target_aligned;
          end
        end
        default: begin
          if (fetch) begin
            id_pc          <= pc;
            id_inst        <= rom_inst;
            id_valid       <= 1'b1;
            pc             <= next_pc;
            branch_pending <= 1'b0;
          end else begin
            // PC is held: remember the redirect so the delay slot still issues first.
            if (branch_flag) begin
              branch_pending <= 1'b1;
              pending_target <= target_aligned;
            end
            if (!stall_id) begin
              id_pc    <= pc;
              id_inst  <= NOP_INST;
              id_valid <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a 64-word zero-latency ROM model.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        stall_if;
  logic        stall_id;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic [31:0] rom_inst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic [0:0]  dbg_state;

  logic [31:0] rom_mem [64];
  logic [98:0] obs;
  logic [98:0] exp_v;
  int          checks;
  int          failures;

  if_stage dut (
    .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .rom_inst(rom_inst), .rom_ce(rom_ce), .rom_addr(rom_addr),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb rom_inst = rom_mem[rom_addr[7:2]];
  assign obs = {dbg_state, rom_ce, rom_addr, id_valid, id_pc, id_inst};

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_if      = 1'b0;
    stall_id      = 1'b0;
    branch_flag   = 1'b0;
    branch_target = 32'h0;
  endtask

  // Reset, release, and take the IDLE->RUN edge: afterwards rom_addr=0 in RUN.
  task automatic start();
    idle_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      exp_v = {1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL reset_hold[%0d] got=%h want=%h", i, obs, exp_v);
      end
      checks++;
    end
    rst = 1'b1;
    step();
    exp_v = {1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL reset_first_run got=%h want=%h", obs, exp_v);
    end
    checks++;
    for (int i = 0; i < 4; i++) begin
      step();
      exp_v = {1'b1, 1'b1, 32'(4 * (i + 1)), 1'b1, 32'(4 * i), rom_mem[i]};
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL startup_seq[%0d] got=%h want=%h", i, obs, exp_v);
      end
      checks++;
    end
  endtask

  task automatic test_sequential();
    start();
    for (int i = 0; i < 43; i++) begin
      step();
      exp_v = {1'b1, 1'b1, 32'(4 * (i + 1)), 1'b1, 32'(4 * i), rom_mem[i]};
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL sequential[%0d] got=%h want=%h", i, obs, exp_v);
      end
      checks++;
    end
  endtask

  task automatic test_stall_if();
    start();
    repeat (4) step();
    stall_if = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_v = {1'b1, 1'b1, 32'h10, 1'b0, 32'h10, 32'h0};
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL stall_if_bubble[%0d] got=%h want=%h", i, obs, exp_v);
      end
      checks++;
    end
    stall_if = 1'b0;
    step();
    exp_v = {1'b1, 1'b1, 32'h14, 1'b1, 32'h10, rom_mem[4]};
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL stall_if_resume got=%h want=%h", obs, exp_v);
    end
    checks++;
  endtask

  task automatic test_stall_id();
    start();
    repeat (3) step();
    stall_id = 1'b1;
    for (int i = 0; i < 2; i++) begin
      stall_if = (i == 1);
      step();
      exp_v = {1'b1, 1'b1, 32'hC, 1'b1, 32'h8, rom_mem[2]};
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL stall_id_hold[%0d] got=%h want=%h", i, obs, exp_v);
      end
      checks++;
    end
    stall_id = 1'b0;
    stall_if = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      exp_v = {1'b1, 1'b1, 32'(16 + 4 * i), 1'b1, 32'(12 + 4 * i), rom_mem[3 + i]};
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL stall_id_resume[%0d] got=%h want=%h", i, obs, exp_v);
      end
      checks++;
    end
  endtask

  task automatic test_branch();
    start();
    repeat (2) step();
    branch_flag   = 1'b1;
    branch_target = 32'h25;
    step();
    branch_flag = 1'b0;
    exp_v = {1'b1, 1'b1, 32'h24, 1'b1, 32'h8, rom_mem[2]};
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL branch_delay_slot got=%h want=%h", obs, exp_v);
    end
    checks++;
    for (int i = 0; i < 2; i++) begin
      step();
      exp_v = {1'b1, 1'b1, 32'(40 + 4 * i), 1'b1, 32'(36 + 4 * i), rom_mem[9 + i]};
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL branch_target_seq[%0d] got=%h want=%h", i, obs, exp_v);
      end
      checks++;
    end
  endtask

  task automatic test_branch_stalled();
    start();
    repeat (2) step();
    stall_if      = 1'b1;
    branch_flag   = 1'b1;
    branch_target = 32'h25;
    for (int i = 0; i < 2; i++) begin
      step();
      branch_flag = 1'b0;
      exp_v = {1'b1, 1'b1, 32'h8, 1'b0, 32'h8, 32'h0};
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL branch_stall_hold[%0d] got=%h want=%h", i, obs, exp_v);
      end
      checks++;
    end
    stall_if = 1'b0;
    step();
    exp_v = {1'b1, 1'b1, 32'h24, 1'b1, 32'h8, rom_mem[2]};
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL branch_stall_apply got=%h want=%h", obs, exp_v);
    end
    checks++;
    step();
    exp_v = {1'b1, 1'b1, 32'h28, 1'b1, 32'h24, rom_mem[9]};
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL branch_stall_target got=%h want=%h", obs, exp_v);
    end
    checks++;
    step();
    exp_v = {1'b1, 1'b1, 32'h2C, 1'b1, 32'h28, rom_mem[10]};
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL branch_pending_cleared got=%h want=%h", obs, exp_v);
    end
    checks++;
  endtask

  task automatic test_branch_overwrite();
    start();
    repeat (2) step();
    stall_id      = 1'b1;
    branch_flag   = 1'b1;
    branch_target = 32'h40;
    step();
    branch_target = 32'h83;
    step();
    stall_id    = 1'b0;
    branch_flag = 1'b0;
    step();
    exp_v = {1'b1, 1'b1, 32'h80, 1'b1, 32'h8, rom_mem[2]};
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL branch_overwrite got=%h want=%h", obs, exp_v);
    end
    checks++;
  endtask

  task automatic test_wrap();
    start();
    branch_flag   = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    step();
    branch_flag = 1'b0;
    step();
    exp_v = {1'b1, 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, rom_mem[63]};
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL pc_wrap got=%h want=%h", obs, exp_v);
    end
    checks++;
  endtask

  task automatic test_idle_branch();
    idle_inputs();
    rst = 1'b0;
    step();
    rst           = 1'b1;
    branch_flag   = 1'b1;
    branch_target = 32'h30;
    stall_if      = 1'b1;
    step();
    branch_flag = 1'b0;
    stall_if    = 1'b0;
    exp_v = {1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL idle_branch_run got=%h want=%h", obs, exp_v);
    end
    checks++;
    step();
    exp_v = {1'b1, 1'b1, 32'h30, 1'b1, 32'h0, rom_mem[0]};
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL idle_branch_apply got=%h want=%h", obs, exp_v);
    end
    checks++;
  endtask

  task automatic test_async_reset();
    start();
    repeat (16) step();
    exp_v = {1'b1, 1'b1, 32'h40, 1'b1, 32'h3C, rom_mem[15]};
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL async_pre got=%h want=%h", obs, exp_v);
    end
    checks++;
    #3;
    rst = 1'b0;
    #1;
    exp_v = {1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL async_clear got=%h want=%h", obs, exp_v);
    end
    checks++;
    step();
    rst = 1'b1;
    step();
    exp_v = {1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL async_idle_cycle got=%h want=%h", obs, exp_v);
    end
    checks++;
    step();
    exp_v = {1'b1, 1'b1, 32'h4, 1'b1, 32'h0, rom_mem[0]};
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL async_restart got=%h want=%h", obs, exp_v);
    end
    checks++;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rom_mem[0] = 32'h3401_1100;
    rom_mem[1] = 32'h3402_0020;
    rom_mem[2] = 32'h3403_0300;
    rom_mem[3] = 32'h3404_4000;
    for (int i = 4; i < 64; i++) rom_mem[i] = 32'h2000_0000 + 32'(i);
    rst = 1'b0;
    idle_inputs();

    test_reset();
    test_sequential();
    test_stall_if();
    test_stall_id();
    test_branch();
    test_branch_stalled();
    test_branch_overwrite();
    test_wrap();
    test_idle_branch();
    test_async_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
